// File: rtl/ip_tx_arbiter_if.sv
// ---------------------------------------------------------------------------
// ip_tx_arbiter_if
// Bundle of every handshake/bus signal around the IP transmit arbiter: the
// S_COUNT packed source-side IP header + payload streams (s_*) and the single
// shared downstream IP header + payload stream (m_*).
//
// Handshake rule for every valid/ready pair here: a transfer happens on a
// rising clk edge where both valid and ready are 1; once valid is raised the
// sender holds valid and its data stable until that transfer happens.
//
// Modports:
//   master : the arbiter itself (consumes s_* requests, drives the m_* bus)
//   slave  : the environment (sources driving s_*, IP stack consuming m_*)
//
// Parameters:
//   S_COUNT : number of requesting sources (1..8)
// ---------------------------------------------------------------------------
interface ip_tx_arbiter_if #(
   parameter int S_COUNT = 2
) ();
   // source side
   logic [S_COUNT-1:0]    s_ip_hdr_valid;
   logic [S_COUNT-1:0]    s_ip_hdr_ready;
   logic [6*S_COUNT-1:0]  s_ip_dscp;
   logic [2*S_COUNT-1:0]  s_ip_ecn;
   logic [16*S_COUNT-1:0] s_ip_length;
   logic [8*S_COUNT-1:0]  s_ip_ttl;
   logic [8*S_COUNT-1:0]  s_ip_protocol;
   logic [32*S_COUNT-1:0] s_ip_source_ip;
   logic [32*S_COUNT-1:0] s_ip_dest_ip;
   logic [8*S_COUNT-1:0]  s_ip_payload_axis_tdata;
   logic [S_COUNT-1:0]    s_ip_payload_axis_tvalid;
   logic [S_COUNT-1:0]    s_ip_payload_axis_tready;
   logic [S_COUNT-1:0]    s_ip_payload_axis_tlast;
   logic [S_COUNT-1:0]    s_ip_payload_axis_tuser;

   // shared downstream side
   logic                  m_ip_hdr_valid;
   logic                  m_ip_hdr_ready;
   logic [5:0]            m_ip_dscp;
   logic [1:0]            m_ip_ecn;
   logic [15:0]           m_ip_length;
   logic [7:0]            m_ip_ttl;
   logic [7:0]            m_ip_protocol;
   logic [31:0]           m_ip_source_ip;
   logic [31:0]           m_ip_dest_ip;
   logic [7:0]            m_ip_payload_axis_tdata;
   logic                  m_ip_payload_axis_tvalid;
   logic                  m_ip_payload_axis_tready;
   logic                  m_ip_payload_axis_tlast;
   logic                  m_ip_payload_axis_tuser;

   modport master (
      input  s_ip_hdr_valid, s_ip_dscp, s_ip_ecn, s_ip_length, s_ip_ttl,
             s_ip_protocol, s_ip_source_ip, s_ip_dest_ip,
             s_ip_payload_axis_tdata, s_ip_payload_axis_tvalid,
             s_ip_payload_axis_tlast, s_ip_payload_axis_tuser,
             m_ip_hdr_ready, m_ip_payload_axis_tready,
      output s_ip_hdr_ready, s_ip_payload_axis_tready,
             m_ip_hdr_valid, m_ip_dscp, m_ip_ecn, m_ip_length, m_ip_ttl,
             m_ip_protocol, m_ip_source_ip, m_ip_dest_ip,
             m_ip_payload_axis_tdata, m_ip_payload_axis_tvalid,
             m_ip_payload_axis_tlast, m_ip_payload_axis_tuser
   );

   modport slave (
      output s_ip_hdr_valid, s_ip_dscp, s_ip_ecn, s_ip_length, s_ip_ttl,
             s_ip_protocol, s_ip_source_ip, s_ip_dest_ip,
             s_ip_payload_axis_tdata, s_ip_payload_axis_tvalid,
             s_ip_payload_axis_tlast, s_ip_payload_axis_tuser,
             m_ip_hdr_ready, m_ip_payload_axis_tready,
      input  s_ip_hdr_ready, s_ip_payload_axis_tready,
             m_ip_hdr_valid, m_ip_dscp, m_ip_ecn, m_ip_length, m_ip_ttl,
             m_ip_protocol, m_ip_source_ip, m_ip_dest_ip,
             m_ip_payload_axis_tdata, m_ip_payload_axis_tvalid,
             m_ip_payload_axis_tlast, m_ip_payload_axis_tuser
   );
endinterface

// File: rtl/ip_tx_arbiter.sv
// ---------------------------------------------------------------------------
// ip_tx_arbiter
// Frame-granular round-robin arbiter sharing one IP transmit interface
// (header + 8-bit payload stream) between S_COUNT sources. A source owns the
// downstream bus from header acceptance until its tlast beat is transferred,
// so frames never interleave. The header is registered; the payload is a
// zero-latency combinational mux of the granted source.
//
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   bus        : ip_tx_arbiter_if.master (s_* sources, m_* shared bus)
//   grant      : one-hot current owner, 0 when idle
//   busy       : high whenever the FSM is not in IDLE
//   dbg_state  : raw FSM state (0 IDLE, 1 HDR, 2 PAYLOAD, 3 DRAIN)
//
// Build option IP_TX_ARB_TIMEOUT_EN: when defined, a source that stops
// offering payload for TIMEOUT_CYCLES cycles has its frame aborted with one
// synthetic error beat (tdata=0, tlast=1, tuser=1) and the rest of its frame
// is drained and discarded. When undefined a stalled source keeps the grant.
// ---------------------------------------------------------------------------
module ip_tx_arbiter #(
   parameter int S_COUNT = 2
`ifdef IP_TX_ARB_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYCLES = 1024
`endif
) (
   input  logic               clk,
   input  logic               rst,
   ip_tx_arbiter_if.master    bus,
   output logic [S_COUNT-1:0] grant,
   output logic               busy,
   output logic [1:0]         dbg_state
);

   localparam int PTR_W = (S_COUNT > 1) ? $clog2(S_COUNT) : 1;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_HDR     = 2'd1,
`ifdef IP_TX_ARB_TIMEOUT_EN
      ST_PAYLOAD = 2'd2,
      ST_DRAIN   = 2'd3
`else
      ST_PAYLOAD = 2'd2
`endif
   } state_t;

   state_t             state_q, state_d;
   logic [PTR_W-1:0]   ptr_q, ptr_d;
   logic [PTR_W-1:0]   sel_q, sel_d;
   logic [S_COUNT-1:0] grant_q, grant_d;
   logic               hdr_valid_q, hdr_valid_d;
   logic [5:0]         dscp_q, dscp_d;
   logic [1:0]         ecn_q, ecn_d;
   logic [15:0]        length_q, length_d;
   logic [7:0]         ttl_q, ttl_d;
   logic [7:0]         protocol_q, protocol_d;
   logic [31:0]        source_ip_q, source_ip_d;
   logic [31:0]        dest_ip_q, dest_ip_d;

`ifdef IP_TX_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0]   cnt_q, cnt_d;
`endif

   // round-robin search results
   logic [PTR_W:0]     cand;
   logic               found;
   logic [PTR_W-1:0]   pick;
   logic [PTR_W-1:0]   ptr_next;

   // granted source payload and combinational outputs
   logic [7:0]         src_tdata;
   logic               src_tvalid, src_tlast, src_tuser;
   logic [S_COUNT-1:0] hdr_ready_c, tready_c;
   logic [7:0]         m_tdata_c;
   logic               m_tvalid_c, m_tlast_c, m_tuser_c;

   assign src_tdata  = bus.s_ip_payload_axis_tdata[8*sel_q +: 8];
   assign src_tvalid = bus.s_ip_payload_axis_tvalid[sel_q];
   assign src_tlast  = bus.s_ip_payload_axis_tlast[sel_q];
   assign src_tuser  = bus.s_ip_payload_axis_tuser[sel_q];

   // pointer moves to the source after the one that just finished
   assign ptr_next = (sel_q == PTR_W'(S_COUNT - 1)) ? '0 : sel_q + 1'b1;

   // first valid header request at or above the pointer, wrapping around
   always_comb begin
      found = 1'b0;
      pick  = '0;
      cand  = '0;
      for (int i = 0; i < S_COUNT; i++) begin
         cand = {1'b0, ptr_q} + (PTR_W+1)'(i);
         if (cand >= (PTR_W+1)'(S_COUNT)) begin
            cand = cand - (PTR_W+1)'(S_COUNT);
         end
         if (!found && bus.s_ip_hdr_valid[cand[PTR_W-1:0]]) begin
            found = 1'b1;
            pick  = cand[PTR_W-1:0];
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      sel_d       = sel_q;
      grant_d     = grant_q;
      hdr_valid_d = hdr_valid_q;
      dscp_d      = dscp_q;
      ecn_d       = ecn_q;
      length_d    = length_q;
      ttl_d       = ttl_q;
      protocol_d  = protocol_q;
      source_ip_d = source_ip_q;
      dest_ip_d   = dest_ip_q;
      hdr_ready_c = '0;
      tready_c    = '0;
      m_tdata_c   = 8'd0;
      m_tvalid_c  = 1'b0;
      m_tlast_c   = 1'b0;
      m_tuser_c   = 1'b0;
`ifdef IP_TX_ARB_TIMEOUT_EN
      cnt_d       = cnt_q;
`endif

      case (state_q)
         ST_IDLE: begin
`ifdef IP_TX_ARB_TIMEOUT_EN
            cnt_d = '0;
`endif
            if (found) begin
               hdr_ready_c[pick] = 1'b1;
               sel_d             = pick;
               grant_d           = '0;
               grant_d[pick]     = 1'b1;
               hdr_valid_d       = 1'b1;
               dscp_d            = bus.s_ip_dscp[6*pick +: 6];
               ecn_d             = bus.s_ip_ecn[2*pick +: 2];
               length_d          = bus.s_ip_length[16*pick +: 16];
               ttl_d             = bus.s_ip_ttl[8*pick +: 8];
               protocol_d        = bus.s_ip_protocol[8*pick +: 8];
               source_ip_d       = bus.s_ip_source_ip[32*pick +: 32];
               dest_ip_d         = bus.s_ip_dest_ip[32*pick +: 32];
               state_d           = ST_HDR;
            end
         end

         ST_HDR: begin
            if (bus.m_ip_hdr_ready) begin
               hdr_valid_d = 1'b0;
               state_d     = ST_PAYLOAD;
            end
         end

         ST_PAYLOAD: begin
`ifdef IP_TX_ARB_TIMEOUT_EN
            if (cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
               // source went silent too long: close the frame with an error beat
               m_tvalid_c = 1'b1;
               m_tlast_c  = 1'b1;
               m_tuser_c  = 1'b1;
               if (bus.m_ip_payload_axis_tready) begin
                  cnt_d   = '0;
                  state_d = ST_DRAIN;
               end
            end else begin
               // only cycles where the source offers nothing count; a
               // downstream stall with data pending clears the counter
               cnt_d = src_tvalid ? '0 : cnt_q + 1'b1;
`endif
               m_tdata_c        = src_tdata;
               m_tvalid_c       = src_tvalid;
               m_tlast_c        = src_tlast;
               m_tuser_c        = src_tuser;
               tready_c[sel_q]  = bus.m_ip_payload_axis_tready;
               if (src_tvalid && src_tlast && bus.m_ip_payload_axis_tready) begin
                  ptr_d   = ptr_next;
                  grant_d = '0;
                  state_d = ST_IDLE;
               end
`ifdef IP_TX_ARB_TIMEOUT_EN
            end
`endif
         end

`ifdef IP_TX_ARB_TIMEOUT_EN
         ST_DRAIN: begin
            // swallow the aborted frame's remaining beats, m side stays quiet
            tready_c[sel_q] = 1'b1;
            if (src_tvalid && src_tlast) begin
               ptr_d   = ptr_next;
               grant_d = '0;
               state_d = ST_IDLE;
            end
         end
`endif

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         ptr_q       <= '0;
         sel_q       <= '0;
         grant_q     <= '0;
         hdr_valid_q <= 1'b0;
         dscp_q      <= '0;
         ecn_q       <= '0;
         length_q    <= '0;
         ttl_q       <= '0;
         protocol_q  <= '0;
         source_ip_q <= '0;
         dest_ip_q   <= '0;
`ifdef IP_TX_ARB_TIMEOUT_EN
         cnt_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         sel_q       <= sel_d;
         grant_q     <= grant_d;
         hdr_valid_q <= hdr_valid_d;
         dscp_q      <= dscp_d;
         ecn_q       <= ecn_d;
         length_q    <= length_d;
         ttl_q       <= ttl_d;
         protocol_q  <= protocol_d;
         source_ip_q <= source_ip_d;
         dest_ip_q   <= dest_ip_d;
`ifdef IP_TX_ARB_TIMEOUT_EN
         cnt_q       <= cnt_d;
`endif
      end
   end

   // the accept pulse is combinational from hdr_valid, so it is masked while
   // reset is held to keep every output at zero
   assign bus.s_ip_hdr_ready           = hdr_ready_c & ~{S_COUNT{rst}};
   assign bus.s_ip_payload_axis_tready = tready_c;

   assign bus.m_ip_hdr_valid           = hdr_valid_q;
   assign bus.m_ip_dscp                = dscp_q;
   assign bus.m_ip_ecn                 = ecn_q;
   assign bus.m_ip_length              = length_q;
   assign bus.m_ip_ttl                 = ttl_q;
   assign bus.m_ip_protocol            = protocol_q;
   assign bus.m_ip_source_ip           = source_ip_q;
   assign bus.m_ip_dest_ip             = dest_ip_q;
   assign bus.m_ip_payload_axis_tdata  = m_tdata_c;
   assign bus.m_ip_payload_axis_tvalid = m_tvalid_c;
   assign bus.m_ip_payload_axis_tlast  = m_tlast_c;
   assign bus.m_ip_payload_axis_tuser  = m_tuser_c;

   assign grant     = grant_q;
   assign busy      = (state_q != ST_IDLE);
   assign dbg_state = state_q;

endmodule

// File: tb/tb_ip_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ip_tx_arbiter
// Directed bench for ip_tx_arbiter with two sources: reset values, a single
// frame, reset mid-frame, round-robin ordering, header/payload backpressure
// and a long source stall that must not move the grant.
// Inputs change on the falling clk edge; outputs are sampled 1 time unit later.
// ---------------------------------------------------------------------------
module tb_ip_tx_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] grant;
   logic       busy;
   logic [1:0] dbg_state;

   int checks = 0;
   int errors = 0;

   logic [7:0] exp_q[$];
   logic [7:0] got_q[$];
   logic       exp_u_q[$];
   logic       got_u_q[$];

   ip_tx_arbiter_if #(.S_COUNT(2)) bus ();

   ip_tx_arbiter #(.S_COUNT(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .grant     (grant),
      .busy      (busy),
      .dbg_state (dbg_state)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- checker ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // ---------------- drivers ----------------
   task automatic hdr_req(input int src, input logic [15:0] len, input logic [7:0] proto,
                          input logic [31:0] dst);
      bus.s_ip_dscp[6*src +: 6]       = 6'(src + 5);
      bus.s_ip_ecn[2*src +: 2]        = 2'(src + 1);
      bus.s_ip_length[16*src +: 16]   = len;
      bus.s_ip_ttl[8*src +: 8]        = 8'd64;
      bus.s_ip_protocol[8*src +: 8]   = proto;
      bus.s_ip_source_ip[32*src +: 32] = 32'h0A00_0001 + 32'(src);
      bus.s_ip_dest_ip[32*src +: 32]  = dst;
      bus.s_ip_hdr_valid[src]         = 1'b1;
   endtask

   // called on a falling edge with the request raised; returns on the falling
   // edge right after the accepting rising edge
   task automatic wait_accept(input int src);
      bit ok = 1'b0;
      for (int k = 0; k < 50 && !ok; k++) begin
         #1;
         if (bus.s_ip_hdr_ready[src]) begin
            ok = 1'b1;
            check("hdr_ready_pulse", 32'(bus.s_ip_hdr_ready), 32'(1 << src));
         end
         @(negedge clk);
      end
      bus.s_ip_hdr_valid[src] = 1'b0;
      check("hdr_accepted", 32'(ok), 32'd1);
   endtask

   // header on the m side one cycle after acceptance
   task automatic chk_hdr(input int src, input logic [15:0] len, input logic [7:0] proto,
                          input logic [31:0] dst);
      #1;
      check("m_hdr_valid", 32'(bus.m_ip_hdr_valid), 32'd1);
      check("grant_owner", 32'(grant), 32'(1 << src));
      check("busy_hdr", 32'(busy), 32'd1);
      check("m_length", 32'(bus.m_ip_length), 32'(len));
      check("m_protocol", 32'(bus.m_ip_protocol), 32'(proto));
      check("m_dest_ip", bus.m_ip_dest_ip, dst);
      check("m_source_ip", bus.m_ip_source_ip, 32'h0A00_0001 + 32'(src));
      check("m_dscp", 32'(bus.m_ip_dscp), 32'(src + 5));
      check("hdr_ready_single", 32'(bus.s_ip_hdr_ready), 32'd0);
      check("tready_in_hdr", 32'(bus.s_ip_payload_axis_tready), 32'd0);
   endtask

   // drives n beats base..base+n-1 from src (tlast on the last one); mode 1
   // toggles m tready 1/0; stop_at >= 0 ends after that many m transfers
   task automatic stream(input int src, input int n, input logic [7:0] base,
                         input int mode, input int stop_at);
      int idx = 0;
      int last_at = 0;
      bit done = 1'b0;
      logic [7:0] d;
      int n_exp;
      got_q.delete();
      exp_q.delete();
      got_u_q.delete();
      exp_u_q.delete();
      n_exp = (stop_at >= 0) ? stop_at : n;
      for (int i = 0; i < n_exp; i++) begin
         d = base + 8'(i);
         exp_q.push_back(d);
         exp_u_q.push_back(d[0]);
      end
      for (int cyc = 0; cyc < 400 && !done; cyc++) begin
         d = base + 8'(idx);
         bus.s_ip_payload_axis_tdata[8*src +: 8] = d;
         bus.s_ip_payload_axis_tvalid[src]       = 1'b1;
         bus.s_ip_payload_axis_tlast[src]        = (idx == n - 1);
         bus.s_ip_payload_axis_tuser[src]        = d[0];
         bus.m_ip_payload_axis_tready            = (mode == 1) ? (cyc % 2 == 0) : 1'b1;
         #1;
         if (bus.m_ip_payload_axis_tvalid && bus.m_ip_payload_axis_tready) begin
            got_q.push_back(bus.m_ip_payload_axis_tdata);
            got_u_q.push_back(bus.m_ip_payload_axis_tuser);
            if (bus.m_ip_payload_axis_tlast) last_at = got_q.size();
         end
         if (bus.s_ip_payload_axis_tready[src] && bus.s_ip_payload_axis_tvalid[src]) idx++;
         @(negedge clk);
         done = (last_at != 0) || (stop_at >= 0 && got_q.size() == stop_at);
      end
      bus.s_ip_payload_axis_tvalid[src] = 1'b0;
      bus.s_ip_payload_axis_tlast[src]  = 1'b0;
      bus.m_ip_payload_axis_tready      = 1'b1;
      check("stream_done", 32'(done), 32'd1);
      check("beat_count", 32'(got_q.size()), 32'(n_exp));
      if (stop_at < 0) check("tlast_position", 32'(last_at), 32'(n));
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         check("beat_data", 32'(got_q[i]), 32'(exp_q[i]));
         check("beat_tuser", 32'(got_u_q[i]), 32'(exp_u_q[i]));
      end
   endtask

   task automatic chk_idle();
      #1;
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_grant", 32'(grant), 32'd0);
      check("idle_m_hdr_valid", 32'(bus.m_ip_hdr_valid), 32'd0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst                          = 1'b1;
      bus.s_ip_hdr_valid           = '0;
      bus.s_ip_dscp                = '0;
      bus.s_ip_ecn                 = '0;
      bus.s_ip_length              = '0;
      bus.s_ip_ttl                 = '0;
      bus.s_ip_protocol            = '0;
      bus.s_ip_source_ip           = '0;
      bus.s_ip_dest_ip             = '0;
      bus.s_ip_payload_axis_tdata  = '0;
      bus.s_ip_payload_axis_tvalid = '0;
      bus.s_ip_payload_axis_tlast  = '0;
      bus.s_ip_payload_axis_tuser  = '0;
      bus.m_ip_hdr_ready           = 1'b1;
      bus.m_ip_payload_axis_tready = 1'b1;

      // reset values, with a request pending that must not be acknowledged
      hdr_req(0, 16'd99, 8'h01, 32'h1);
      repeat (2) @(negedge clk);
      #1;
      check("rst_hdr_ready", 32'(bus.s_ip_hdr_ready), 32'd0);
      check("rst_grant", 32'(grant), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_m_hdr_valid", 32'(bus.m_ip_hdr_valid), 32'd0);
      check("rst_m_tvalid", 32'(bus.m_ip_payload_axis_tvalid), 32'd0);
      check("rst_m_length", 32'(bus.m_ip_length), 32'd0);
      bus.s_ip_hdr_valid = '0;
      @(negedge clk);
      rst = 1'b0;

      // single frame from src0
      @(negedge clk);
      hdr_req(0, 16'd28, 8'h11, 32'hC0A8_0001);
      wait_accept(0);
      chk_hdr(0, 16'd28, 8'h11, 32'hC0A8_0001);
      stream(0, 8, 8'h00, 0, -1);
      chk_idle();

      // reset during beat 3 of a 10-beat frame
      @(negedge clk);
      hdr_req(0, 16'd40, 8'h06, 32'hC0A8_0002);
      wait_accept(0);
      chk_hdr(0, 16'd40, 8'h06, 32'hC0A8_0002);
      stream(0, 10, 8'h80, 0, 3);
      bus.s_ip_payload_axis_tdata[7:0] = 8'h83;
      bus.s_ip_payload_axis_tvalid[0]  = 1'b1;
      rst = 1'b1;
      #1;
      check("midrst_grant", 32'(grant), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_m_tvalid", 32'(bus.m_ip_payload_axis_tvalid), 32'd0);
      check("midrst_m_tlast", 32'(bus.m_ip_payload_axis_tlast), 32'd0);
      check("midrst_s_tready", 32'(bus.s_ip_payload_axis_tready), 32'd0);
      check("midrst_m_length", 32'(bus.m_ip_length), 32'd0);
      check("midrst_state", 32'(dbg_state), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      bus.s_ip_payload_axis_tvalid[0] = 1'b0;
      @(negedge clk);
      hdr_req(1, 16'd50, 8'h11, 32'hC0A8_0003);
      wait_accept(1);
      chk_hdr(1, 16'd50, 8'h11, 32'hC0A8_0003);
      stream(1, 4, 8'h20, 0, -1);
      chk_idle();

      // simultaneous requests, pointer 0: src0 first, src1 after one idle cycle
      @(negedge clk);
      hdr_req(0, 16'd60, 8'h11, 32'hC0A8_0010);
      hdr_req(1, 16'd70, 8'h06, 32'hC0A8_0011);
      wait_accept(0);
      chk_hdr(0, 16'd60, 8'h11, 32'hC0A8_0010);
      stream(0, 3, 8'h30, 0, -1);
      #1;
      check("gap_busy", 32'(busy), 32'd0);
      check("gap_next_accept", 32'(bus.s_ip_hdr_ready), 32'b10);
      wait_accept(1);
      chk_hdr(1, 16'd70, 8'h06, 32'hC0A8_0011);
      stream(1, 3, 8'h38, 0, -1);

      // src0 alone moves the pointer to 1; simultaneous requests then favour src1
      @(negedge clk);
      hdr_req(0, 16'd80, 8'h11, 32'hC0A8_0020);
      wait_accept(0);
      chk_hdr(0, 16'd80, 8'h11, 32'hC0A8_0020);
      stream(0, 2, 8'h50, 0, -1);
      @(negedge clk);
      hdr_req(0, 16'd81, 8'h11, 32'hC0A8_0021);
      hdr_req(1, 16'd91, 8'h06, 32'hC0A8_0031);
      wait_accept(1);
      chk_hdr(1, 16'd91, 8'h06, 32'hC0A8_0031);
      stream(1, 2, 8'h58, 0, -1);
      wait_accept(0);
      chk_hdr(0, 16'd81, 8'h11, 32'hC0A8_0021);
      stream(0, 2, 8'h60, 0, -1);
      chk_idle();

      // header held 5 cycles, then payload with toggling tready
      @(negedge clk);
      bus.m_ip_hdr_ready = 1'b0;
      hdr_req(1, 16'd123, 8'h11, 32'hC0A8_0040);
      wait_accept(1);
      chk_hdr(1, 16'd123, 8'h11, 32'hC0A8_0040);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         #1;
         check("hold_hdr_valid", 32'(bus.m_ip_hdr_valid), 32'd1);
         check("hold_length", 32'(bus.m_ip_length), 32'd123);
         check("hold_dest_ip", bus.m_ip_dest_ip, 32'hC0A8_0040);
         check("hold_tready", 32'(bus.s_ip_payload_axis_tready), 32'd0);
      end
      @(negedge clk);
      bus.m_ip_hdr_ready = 1'b1;
      stream(1, 6, 8'h70, 1, -1);
      chk_idle();

      // src0 stalls after 2 beats: grant must stay, src1 must wait
      @(negedge clk);
      hdr_req(0, 16'd200, 8'h11, 32'hC0A8_0050);
      hdr_req(1, 16'd201, 8'h11, 32'hC0A8_0051);
      wait_accept(0);
      chk_hdr(0, 16'd200, 8'h11, 32'hC0A8_0050);
      stream(0, 4, 8'h40, 0, 2);
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         #1;
         if (k % 20 == 0) begin
            check("stall_grant", 32'(grant), 32'b01);
            check("stall_src1_ready", 32'(bus.s_ip_hdr_ready[1]), 32'd0);
            check("stall_m_tvalid", 32'(bus.m_ip_payload_axis_tvalid), 32'd0);
         end
      end
      @(negedge clk);
      stream(0, 2, 8'h42, 0, -1);
      wait_accept(1);
      chk_hdr(1, 16'd201, 8'h11, 32'hC0A8_0051);
      stream(1, 2, 8'h48, 0, -1);
      chk_idle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
